aes_mix_columns_unit: RTL and testbench

- Applies the AES MixColumns transform, forward or inverse, to one 32-bit state column.
- Sits in the round datapath of the AES accelerator, after ShiftRows (encrypt) or before InvShiftRows (decrypt).
- Default build is purely combinational.
- An optional output register stage is available for timing closure.

---
 rtl/aes_mix_columns_unit.sv | 71 +++++++
 tb/tb_aes_mix_columns_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_mix_columns_unit.sv
// rtl/aes_mix_columns_unit.sv - AES MixColumns / InvMixColumns on one 32-bit state column
module aes_mix_columns_unit #(
    parameter int REG_OUT = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fwd_ninv_i,
    input  logic [31:0] col_i,
    output logic [31:0] col_o
);

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0]  a_byte [4];
    logic [7:0]  x2     [4];
    logic [7:0]  x4     [4];
    logic [7:0]  x8     [4];
    logic [7:0]  fwd_b  [4];
    logic [7:0]  inv_b  [4];
    logic [7:0]  x8_all;
    logic [31:0] mix_col;

    // Per-byte xtime chain, evaluated once and shared by both directions.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            a_byte[i] = col_i[31-8*i -: 8];
            x2[i]     = xtime(a_byte[i]);
            x4[i]     = xtime(x2[i]);
            x8[i]     = xtime(x4[i]);
        end
    end

    // The inverse matrix is the forward one plus 8*(sum of all bytes)
    // plus 4*(a_i ^ a_{i+2}), since E^2 = D^1 = C and B^3 = 9^1 = 8.
    always_comb begin
        x8_all  = x8[0] ^ x8[1] ^ x8[2] ^ x8[3];
        mix_col = 32'h0;
        for (int i = 0; i < 4; i++) begin
            fwd_b[i] = x2[i] ^ x2[(i+1)%4] ^ a_byte[(i+1)%4]
                     ^ a_byte[(i+2)%4] ^ a_byte[(i+3)%4];
            inv_b[i] = fwd_b[i] ^ x8_all ^ x4[i] ^ x4[(i+2)%4];
            mix_col[31-8*i -: 8] = fwd_ninv_i ? fwd_b[i] : inv_b[i];
        end
    end

    generate
        if (REG_OUT != 0) begin : g_reg_out
            logic [31:0] col_q;

            // Output register; reset clears it and discards any pending result.
            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    col_q <= 32'h0;
                end else begin
                    col_q <= mix_col;
                end
            end

            assign col_o = col_q;
        end else begin : g_comb_out
            logic unused_clk_rst;

            assign unused_clk_rst = clk_i ^ rst_i;
            assign col_o          = mix_col;
        end
    endgenerate

endmodule

// File: tb/tb_aes_mix_columns_unit.sv
// tb/tb_aes_mix_columns_unit.sv - self-checking bench for aes_mix_columns_unit
module tb_aes_mix_columns_unit;

    int n_vec = 0;
    int n_err = 0;

    // Combinational instances: clock and reset held low throughout.
    logic        comb_clk = 1'b0;
    logic        comb_rst = 1'b0;
    logic        fwd_on   = 1'b1;
    logic        fwd_off  = 1'b0;

    logic        dut_fwd;
    logic [31:0] dut_col_i;
    logic [31:0] dut_col_o;

    logic [31:0] rt_in;
    logic [31:0] rt_mid_fi, rt_out_fi;
    logic [31:0] rt_mid_if, rt_out_if;

    // Registered instance.
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reg_fwd;
    logic [31:0] reg_col_i;
    logic [31:0] reg_col_o;

    always #5 clk = ~clk;

    aes_mix_columns_unit #(.REG_OUT(0)) u_dut (
        .clk_i(comb_clk), .rst_i(comb_rst), .fwd_ninv_i(dut_fwd),
        .col_i(dut_col_i), .col_o(dut_col_o));

    aes_mix_columns_unit #(.REG_OUT(0)) u_rt_fwd1 (
        .clk_i(comb_clk), .rst_i(comb_rst), .fwd_ninv_i(fwd_on),
        .col_i(rt_in), .col_o(rt_mid_fi));
    aes_mix_columns_unit #(.REG_OUT(0)) u_rt_inv1 (
        .clk_i(comb_clk), .rst_i(comb_rst), .fwd_ninv_i(fwd_off),
        .col_i(rt_mid_fi), .col_o(rt_out_fi));

    aes_mix_columns_unit #(.REG_OUT(0)) u_rt_inv2 (
        .clk_i(comb_clk), .rst_i(comb_rst), .fwd_ninv_i(fwd_off),
        .col_i(rt_in), .col_o(rt_mid_if));
    aes_mix_columns_unit #(.REG_OUT(0)) u_rt_fwd2 (
        .clk_i(comb_clk), .rst_i(comb_rst), .fwd_ninv_i(fwd_on),
        .col_i(rt_mid_if), .col_o(rt_out_if));

    aes_mix_columns_unit #(.REG_OUT(1)) u_reg (
        .clk_i(clk), .rst_i(rst_n), .fwd_ninv_i(reg_fwd),
        .col_i(reg_col_i), .col_o(reg_col_o));

    // Generic GF(2^8) multiply by shift-and-add.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h0;
        logic [7:0] aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p ^= aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Circulant matrix product with the spec's coefficient row.
    function automatic logic [31:0] mix_ref(input logic [31:0] col, input logic fwd);
        logic [7:0] a [4];
        logic [7:0] c [4];
        logic [7:0] b;
        logic [31:0] r = 32'h0;
        if (fwd) begin
            c[0] = 8'h02; c[1] = 8'h03; c[2] = 8'h01; c[3] = 8'h01;
        end else begin
            c[0] = 8'h0e; c[1] = 8'h0b; c[2] = 8'h0d; c[3] = 8'h09;
        end
        for (int i = 0; i < 4; i++) a[i] = col[31-8*i -: 8];
        for (int i = 0; i < 4; i++) begin
            b = 8'h0;
            for (int j = 0; j < 4; j++) b ^= gmul(c[j], a[(i+j)%4]);
            r[31-8*i -: 8] = b;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic apply_comb(input logic fwd, input logic [31:0] col);
        dut_fwd   = fwd;
        dut_col_i = col;
        #1;
    endtask

    logic [31:0] vec_in  [6];
    logic [31:0] vec_out [6];
    logic        vec_fwd [6];
    logic [31:0] fixed   [3];
    logic [31:0] v, exp_q;
    logic        f;

    initial begin
        vec_in[0] = 32'hdb135345; vec_out[0] = 32'h8e4da1bc; vec_fwd[0] = 1'b1;
        vec_in[1] = 32'hf20a225c; vec_out[1] = 32'h9fdc589d; vec_fwd[1] = 1'b1;
        vec_in[2] = 32'hd4d4d4d5; vec_out[2] = 32'hd5d5d7d6; vec_fwd[2] = 1'b1;
        vec_in[3] = 32'h2d26314c; vec_out[3] = 32'h4d7ebdf8; vec_fwd[3] = 1'b1;
        vec_in[4] = 32'h8e4da1bc; vec_out[4] = 32'hdb135345; vec_fwd[4] = 1'b0;
        vec_in[5] = 32'h9fdc589d; vec_out[5] = 32'hf20a225c; vec_fwd[5] = 1'b0;
        fixed[0] = 32'h01010101; fixed[1] = 32'hc6c6c6c6; fixed[2] = 32'h00000000;

        dut_fwd = 1'b1; dut_col_i = 32'h0; rt_in = 32'h0;
        reg_fwd = 1'b1; reg_col_i = 32'h0;
        #1;

        // Registered instance in reset from time zero.
        check("reg_reset_state", reg_col_o, 32'h0);

        // Known-answer vectors and fixed points.
        for (int i = 0; i < 6; i++) begin
            apply_comb(vec_fwd[i], vec_in[i]);
            check($sformatf("kat%0d", i), dut_col_o, vec_out[i]);
        end
        for (int i = 0; i < 3; i++) begin
            apply_comb(1'b1, fixed[i]);
            check($sformatf("fixed_fwd%0d", i), dut_col_o, fixed[i]);
            apply_comb(1'b0, fixed[i]);
            check($sformatf("fixed_inv%0d", i), dut_col_o, fixed[i]);
        end

        // Exhaustive multipliers: column {a,0,0,0} exposes 2,1,1,3 and E,9,D,B.
        for (int a = 0; a < 256; a++) begin
            apply_comb(1'b1, {a[7:0], 24'h0});
            check("mul_fwd", dut_col_o,
                  {gmul(a[7:0], 8'h02), a[7:0], a[7:0], gmul(a[7:0], 8'h03)});
            apply_comb(1'b0, {a[7:0], 24'h0});
            check("mul_inv", dut_col_o,
                  {gmul(a[7:0], 8'h0e), gmul(a[7:0], 8'h09),
                   gmul(a[7:0], 8'h0d), gmul(a[7:0], 8'h0b)});
        end

        // Round trips on the known vectors, then random columns.
        for (int i = 0; i < 6; i++) begin
            rt_in = vec_in[i];
            #1;
            check("rt_kat_fi", rt_out_fi, vec_in[i]);
            check("rt_kat_if", rt_out_if, vec_in[i]);
        end
        for (int i = 0; i < 10000; i++) begin
            v = $urandom;
            f = 1'($urandom_range(0, 1));
            rt_in = v;
            apply_comb(f, v);
            check("rand_model", dut_col_o, mix_ref(v, f));
            check("rt_fwd_inv", rt_out_fi, v);
            check("rt_inv_fwd", rt_out_if, v);
        end

        // Registered: reset holds zero across edges regardless of input.
        @(negedge clk);
        reg_col_i = 32'hdb135345; reg_fwd = 1'b1;
        @(posedge clk); #1;
        check("reg_held_in_reset", reg_col_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reg_after_release", reg_col_o, 32'h0);
        @(posedge clk); #1;
        check("reg_first_edge", reg_col_o, 32'h8e4da1bc);

        // Random pipelined vectors with direction changing every cycle.
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            v = $urandom;
            f = 1'($urandom_range(0, 1));
            reg_col_i = v; reg_fwd = f;
            exp_q = mix_ref(v, f);
            @(posedge clk); #1;
            check("reg_rand", reg_col_o, exp_q);
        end

        // Asynchronous reset mid-cycle clears the output immediately.
        #1;
        rst_n = 1'b0;
        #1;
        check("reg_async_clear", reg_col_o, 32'h0);

        // Pending input is discarded while reset is held through an edge.
        @(negedge clk);
        reg_col_i = 32'hf20a225c; reg_fwd = 1'b1;
        @(posedge clk); #1;
        check("reg_pending_discard", reg_col_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("reg_after_rerelease", reg_col_o, 32'h9fdc589d);

        // Combinational result unaffected by held-low clock and reset.
        apply_comb(1'b1, 32'hdb135345);
        check("comb_reset_ignored", dut_col_o, 32'h8e4da1bc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
